pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor and successor to the team's fixed 5-bit gate-level CLA. The WIDTH-bit operand is split into BLOCK-bit lookahead groups, with one group resolved per pipeline stage and the inter-group carry registered between stages. It has a valid/ready handshake with full back-pressure, an add/subtract mode, and a signed-overflow flag. It is the arithmetic datapath for the team's accumulator and ALU blocks.

---
 rtl/cla_pkg.sv | 41 ++++
 rtl/cla_group.sv | 38 +++
 rtl/pipelined_cla_addsub.sv | 111 +++++++++++
 tb/tb_pipelined_cla_addsub.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared lookahead helpers and parameter check for the pipelined CLA
package cla_pkg;

    localparam int MAX_BLOCK = 8;

    typedef logic [MAX_BLOCK-1:0] grp_vec_t;

    function automatic grp_vec_t grp_generate(input grp_vec_t a, input grp_vec_t b);
        return a & b;
    endfunction

    function automatic grp_vec_t grp_propagate(input grp_vec_t a, input grp_vec_t b);
        return a ^ b;
    endfunction

    // Flattened carry into bit n: c0·P[n-1:0] | OR_j G_j·P[n-1:j+1].
    function automatic logic grp_carry(input grp_vec_t g, input grp_vec_t p,
                                       input logic c0, input int n);
        logic c;
        logic t;
        c = c0;
        for (int k = 0; k < MAX_BLOCK; k++) begin
            if (k < n) c = c & p[k];
        end
        for (int j = 0; j < MAX_BLOCK; j++) begin
            if (j < n) begin
                t = g[j];
                for (int k = j + 1; k < MAX_BLOCK; k++) begin
                    if (k < n) t = t & p[k];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

    function automatic bit cfg_ok(input int width, input int block);
        return (block >= 1) && (block <= MAX_BLOCK) && (width >= block) && (width % block == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational BLOCK-bit carry-lookahead group
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    grp_vec_t         a_w;
    grp_vec_t         b_w;
    grp_vec_t         g;
    grp_vec_t         p;
    logic [BLOCK:0]   c;

    always_comb begin
        a_w = '0;
        b_w = '0;
        a_w[BLOCK-1:0] = a;
        b_w[BLOCK-1:0] = b;
        g = grp_generate(a_w, b_w);
        p = grp_propagate(a_w, b_w);
        c = '0;
        for (int i = 0; i <= BLOCK; i++) begin
            c[i] = grp_carry(g, p, c_in, i);
        end
    end

    assign s     = p[BLOCK-1:0] ^ c[BLOCK-1:0];
    assign c_out = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined CLA adder/subtractor, one lookahead group per stage
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / BLOCK;

    if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_check
        $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK in 1..8");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves as one; bubbles are kept so latency is fixed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             carry_in;
        logic [BLOCK-1:0] grp_s;
        logic             grp_cout;
        logic             grp_cmsb;
        logic [WIDTH-1:0] sum_d;
        logic             valid_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             carry_q;
        logic             ovf_q;

        if (k == 0) begin : g_first
            assign v_in     = in_valid;
            assign a_in     = a;
            assign b_in     = b_eff;
            assign sum_in   = '0;
            assign carry_in = c0;
        end else begin : g_next
            assign v_in     = g_stage[k-1].valid_q;
            assign a_in     = g_stage[k-1].a_q;
            assign b_in     = g_stage[k-1].b_q;
            assign sum_in   = g_stage[k-1].sum_q;
            assign carry_in = g_stage[k-1].carry_q;
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a     (a_in[k*BLOCK +: BLOCK]),
            .b     (b_in[k*BLOCK +: BLOCK]),
            .c_in  (carry_in),
            .s     (grp_s),
            .c_out (grp_cout),
            .c_msb (grp_cmsb)
        );

        always_comb begin
            sum_d = sum_in;
            sum_d[k*BLOCK +: BLOCK] = grp_s;
        end

        // Data only loads behind a valid token so the output holds its last result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                a_q     <= '0;
                b_q     <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (adv) begin
                valid_q <= v_in;
                if (v_in) begin
                    sum_q   <= sum_d;
                    a_q     <= a_in;
                    b_q     <= b_in;
                    carry_q <= grp_cout;
                    ovf_q   <= grp_cmsb ^ grp_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[NGRP-1].valid_q;
    assign sum       = g_stage[NGRP-1].sum_q;
    assign cout      = g_stage[NGRP-1].carry_q;
    assign ovf       = g_stage[NGRP-1].ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - scoreboard bench for three CLA configurations
module tb_pipelined_cla_addsub;

    typedef logic [33:0] exp_t;

    logic        clk;
    logic [2:0]  rst_s;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [2:0]  cin_s;
    logic [2:0]  sub_s;
    logic [2:0]  ov;
    logic [2:0]  ordy;
    logic [2:0]  co_s;
    logic [2:0]  of_s;
    logic [2:0]  rnd_en;
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic [31:0] sum_s [3];
    logic [15:0] sum0;
    logic [4:0]  sum1;
    logic [31:0] sum2;
    int          W [3] = '{16, 5, 32};

    int   nchk;
    int   nfail;
    int   cyc;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   t0[$];
    logic [2:0] stall;
    exp_t hold [3];
    exp_t m_got;
    exp_t m_exp;
    logic m_have;

    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0][15:0]), .b(b_s[0][15:0]), .cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0), .cout(co_s[0]), .ovf(of_s[0])
    );

    pipelined_cla_addsub #(.WIDTH(5), .BLOCK(5)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1][4:0]), .b(b_s[1][4:0]), .cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .cout(co_s[1]), .ovf(of_s[1])
    );

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) u_dut2 (
        .clk(clk), .rst(rst_s[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2), .cout(co_s[2]), .ovf(of_s[2])
    );

    assign sum_s[0] = {16'b0, sum0};
    assign sum_s[1] = {27'b0, sum1};
    assign sum_s[2] = sum2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain two's-complement arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic cv, input logic sv);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] be;
        logic [32:0] full;
        logic [31:0] s;
        logic        co;
        logic        vf;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = av & mask;
        be   = (sv ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, be} + {32'b0, (sv ? 1'b1 : cv)};
        s    = full[31:0] & mask;
        co   = full[w];
        vf   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {vf, co, s};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int d, output logic have, output exp_t e);
        have = 1'b0;
        e    = '0;
        if (qsize(d) != 0) begin
            have = 1'b1;
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    // Issue one operation; operands are scrambled while the block is not ready.
    task automatic send(input int id, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic sv);
        int n;
        n = 0;
        iv[id]    = 1'b1;
        a_s[id]   = $urandom;
        b_s[id]   = $urandom;
        cin_s[id] = 1'($urandom);
        sub_s[id] = 1'($urandom);
        @(negedge clk);
        while (!ir[id] && n < 200) begin
            a_s[id] = $urandom;
            b_s[id] = $urandom;
            @(negedge clk);
            n++;
        end
        if (!ir[id]) begin
            check($sformatf("send_timeout%0d", id), 64'(ir[id]), 64'd1);
            iv[id] = 1'b0;
        end else begin
            a_s[id]   = av;
            b_s[id]   = bv;
            cin_s[id] = cv;
            sub_s[id] = sv;
            qpush(id, model(W[id], av, bv, cv, sv));
            @(posedge clk);
            #1;
            iv[id] = 1'b0;
        end
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (qsize(id) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain%0d", id), 64'(qsize(id)), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic latency(input int id, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic sv, input int lat_exp);
        int lat;
        send(id, av, bv, cv, sv);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (ov[id]) break;
        end
        check($sformatf("latency%0d", id), 64'(lat), 64'(lat_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_stream(input int id, input int n);
        rnd_en[id] = 1'b1;
        repeat (n) begin
            if ($urandom_range(7) == 0) begin
                @(posedge clk);
                #1;
            end
            send(id, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        rnd_en[id] = 1'b0;
        ordy[id]   = 1'b1;
        drain(id);
    endtask

    task automatic main_seq();
        latency(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 4);
        send(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
        send(0, 32'h0000, 32'h0001, 1'b0, 1'b1);
        drain(0);

        t0.delete();
        send(0, 32'h1234, 32'h4321, 1'b0, 1'b0);
        send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
        repeat (6) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        drain(0);
        check("stream_count", 64'(t0.size()), 64'd8);
        if (t0.size() == 8) check("stream_spacing", 64'(t0[7] - t0[0]), 64'd7);

        repeat (4) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        ordy[0] = 1'b0;
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(ir[0]), 64'd0);
                end
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
            send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        join
        drain(0);

        repeat (3) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        q0.delete();
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(ov[0]), 64'd0);
        check("rst_in_ready", 64'(ir[0]), 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;

        rnd_stream(0, 300);
    endtask

    task automatic sweep(input int id, input int lat_exp);
        latency(id, $urandom, $urandom, 1'($urandom), 1'($urandom), lat_exp);
        rnd_stream(id, 10000);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_got = {of_s[d], co_s[d], sum_s[d]};
            if (rst_s[d]) begin
                stall[d] = 1'b0;
            end else begin
                if (stall[d]) begin
                    check($sformatf("stall_hold%0d", d), {29'b0, ov[d], m_got}, {29'b0, 1'b1, hold[d]});
                end
                if (ov[d] && ordy[d]) begin
                    qpop(d, m_have, m_exp);
                    if (!m_have) begin
                        check($sformatf("unexpected_result%0d", d), 64'(m_got), 64'h0_DEAD_BEEF_0);
                    end else begin
                        check($sformatf("result%0d", d), 64'(m_got), 64'(m_exp));
                    end
                    if (d == 0) t0.push_back(cyc);
                end
                stall[d] = ov[d] && !ordy[d];
                hold[d]  = m_got;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rnd_en[d]) ordy[d] = ($urandom_range(3) != 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nchk   = 0;
        nfail  = 0;
        rst_s  = 3'b111;
        iv     = 3'b000;
        ordy   = 3'b111;
        rnd_en = 3'b000;
        cin_s  = 3'b000;
        sub_s  = 3'b000;
        stall  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            a_s[d]  = '0;
            b_s[d]  = '0;
            hold[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_s = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_out_valid%0d", d), 64'(ov[d]), 64'd0);
            check($sformatf("reset_sum%0d", d), 64'(sum_s[d]), 64'd0);
            check($sformatf("reset_cout%0d", d), 64'(co_s[d]), 64'd0);
            check($sformatf("reset_ovf%0d", d), 64'(of_s[d]), 64'd0);
            check($sformatf("reset_in_ready%0d", d), 64'(ir[d]), 64'd1);
        end
        @(posedge clk);
        #1;
        fork
            main_seq();
            sweep(1, 1);
            sweep(2, 4);
        join
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
